pipe_ctrl_unit: RTL
===================

# pipe_ctrl_unit

Pipelined MIPS control unit: decodes the ID-stage opcode and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers, so each stage receives its own signals. It owns load-use hazard detection (bubble insertion plus IF/ID stall) and branch flushing (squash on a taken branch resolved in MEM). It keeps saturating bubble and flush counters for performance debug. It sits beside the datapath pipeline registers and replaces the purely combinational decoder.

## Interface
- REG_W, 5, register-specifier width
- CNT_W, 16, width of each performance counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  the IF/ID register holds a real instruction
- id_opcode  in  6  opcode of the instruction in ID
- id_rs, id_rt  in  REG_W  source specifiers of the instruction in ID
- mem_zero  in  1  ALU zero flag from the EX/MEM register
- ex_alusrc, ex_regdst  out  1  EX-stage controls
- ex_aluop  out  2  00 add, 01 sub, 10 funct, 11 or
- mem_branch, mem_memread, mem_memwrite  out  1  MEM-stage controls
- wb_regwrite, wb_memtoreg  out  1  WB-stage controls
- pc_src  out  1  comb. mem_branch & mem_zero; selects the branch target
- stall  out  1  comb.; hold the PC and IF/ID
- flush  out  1  comb. equals pc_src; IF/ID loads a NOP
- id_illegal  out  1  comb. id_valid & unrecognised opcode
- bubble_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation
- Decode (ID):
  - LW 100011: alusrc, memread, regwrite, memtoreg, aluop 00.
  - SW 101011: alusrc, memwrite, aluop 00.
  - BEQ 000100: branch, aluop 01.
  - R-type 000000: regdst, regwrite, aluop 10.
  - Any other opcode, or id_valid=0: all controls zero.
- ID/EX register holds the full bundle plus ex_rt (REG_W) and ex_valid.
- EX/MEM register holds the MEM and WB fields plus mem_valid.
- MEM/WB register holds the WB fields.
- rt use:
  - LW (and the immediate ops) use rs only.
  - R-type, SW and BEQ use both rs and rt.
- Load-use hazard: ex_valid & ex_memread & id_valid & (ex_rt==id_rs | (uses_rt & ex_rt==id_rt)).
  - ex_rt==0 still counts as a hazard; the block does no zero-register filtering.
- On a hazard (no flush):
  - stall=1.
  - ID/EX loads a bubble: all controls 0, ex_valid 0.
  - EX/MEM and MEM/WB advance normally.
- On pc_src=1:
  - flush=1.
  - ID/EX and EX/MEM load bubbles, squashing the instructions in ID and EX.
  - MEM/WB advances normally.
- Simultaneous hazard and flush: flush wins, stall=0, and only flush_cnt increments.
- bubble_cnt increments on each stall cycle; flush_cnt increments on each flush cycle. Both hold at 2^CNT_W-1.

## Timing
- Reset (async assert, sync deassert by the environment):
  - All pipeline registers clear to 0, so every ex_/mem_/wb_ output is 0 and pc_src, flush and stall are 0.
  - Both counters are 0.
  - Reset mid-stall or mid-flush discards in-flight state immediately.
- Latency: an opcode present in ID at edge N drives ex_* after N, mem_* after N+1, wb_* after N+2.
- A stall lasts exactly one cycle: the bubble clears ex_memread, so the held instruction re-issues on the next edge.
- pc_src, flush and stall are combinational within a cycle from registered state plus the ID inputs. No comb. path exists from the ex_/mem_/wb_ outputs back to inputs.

## Configuration
- CTRL_IMM_OPS_EN defined:
  - ADDI 001000 decodes as alusrc, regwrite, aluop 00.
  - ORI 001101 decodes as alusrc, regwrite, aluop 11.
  - Both are rs-only.
- CTRL_IMM_OPS_EN undefined: 001000 and 001101 are unrecognised, so controls are zero and id_illegal=1.

## Test plan
- Reset: rst_n=0 mid-stream with an LW in EX → all outputs 0 and counters 0 asynchronously, before the next edge.
- LW $t1 (rt=9) then ADD using rs=9 → stall=1 for one cycle, ex_* all 0 next cycle, ADD reaches EX one cycle late, bubble_cnt=1.
- LW rt=9 then LW rs=5 rt=9 → no stall (rt unused by LW), bubble_cnt stays 0.
- BEQ with mem_zero=1 in MEM, LW in EX, hazard-causing instruction in ID → flush=1, stall=0, pc_src=1, next-cycle ex_*/mem_* zero, flush_cnt=1, bubble_cnt unchanged.
- Pipeline flow: R-type at edge 0 → ex_aluop=10 after edge 0, wb_regwrite=1 after edge 2. SW → mem_memwrite=1 after edge 1, wb_regwrite=0.
- Opcode 001101: with CTRL_IMM_OPS_EN → ex_aluop=11, ex_alusrc=1. Without → id_illegal=1 and all controls zero. With CNT_W=2, 5 stalls → bubble_cnt=3.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control unit: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, branch flush, saturating perf counters. Option macro: CTRL_IMM_OPS_EN (ADDI/ORI).
module pipe_ctrl_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             id_valid_i,
  input  logic [5:0]       id_opcode_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             mem_zero_i,
  output logic             ex_alusrc_o,
  output logic             ex_regdst_o,
  output logic [1:0]       ex_aluop_o,
  output logic             mem_branch_o,
  output logic             mem_memread_o,
  output logic             mem_memwrite_o,
  output logic             wb_regwrite_o,
  output logic             wb_memtoreg_o,
  output logic             pc_src_o,
  output logic             stall_o,
  output logic             flush_o,
  output logic             id_illegal_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic       alusrc;
    logic       regdst;
    logic [1:0] aluop;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
  } ctrl_t;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
    logic regwrite;
    logic memtoreg;
  } mem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  ctrl_t            dec;
  logic             uses_rt, known, hazard;
  ctrl_t            ex_q, ex_d;
  logic [REG_W-1:0] ex_rt_q, ex_rt_d;
  logic             ex_valid_q, ex_valid_d;
  mem_ctrl_t        mem_q, mem_d;
  logic             mem_valid_q, mem_valid_d;
  wb_ctrl_t         wb_q, wb_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    dec     = '0;
    uses_rt = 1'b0;
    known   = 1'b1;
    case (id_opcode_i)
      OP_LW: begin
        dec.alusrc   = 1'b1;
        dec.memread  = 1'b1;
        dec.regwrite = 1'b1;
        dec.memtoreg = 1'b1;
      end
      OP_SW: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        uses_rt      = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.aluop  = 2'b01;
        uses_rt    = 1'b1;
      end
      OP_R: begin
        dec.regdst   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = 2'b10;
        uses_rt      = 1'b1;
      end
`ifdef CTRL_IMM_OPS_EN
      OP_ADDI: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
      end
      OP_ORI: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = 2'b11;
      end
`endif
      default: known = 1'b0;
    endcase
  end

  // ex_rt==0 is deliberately not filtered: a load to $zero still stalls its consumer.
  assign hazard = ex_valid_q & ex_q.memread & id_valid_i &
                  ((ex_rt_q == id_rs_i) | (uses_rt & (ex_rt_q == id_rt_i)));
  assign pc_src_o     = mem_valid_q & mem_q.branch & mem_zero_i;
  assign flush_o      = pc_src_o;
  assign stall_o      = hazard & ~flush_o;
  assign id_illegal_o = id_valid_i & ~known;

  always_comb begin
    ex_d        = dec;
    ex_valid_d  = 1'b1;
    ex_rt_d     = id_rt_i;
    if (flush_o || stall_o || !id_valid_i) begin
      ex_d       = '0;
      ex_valid_d = 1'b0;
    end
    mem_d       = {ex_q.branch, ex_q.memread, ex_q.memwrite, ex_q.regwrite, ex_q.memtoreg};
    mem_valid_d = ex_valid_q;
    if (flush_o) begin
      mem_d       = '0;
      mem_valid_d = 1'b0;
    end
    wb_d         = {mem_q.regwrite, mem_q.memtoreg};
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (stall_o && bubble_cnt_q != CNT_MAX) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    if (flush_o && flush_cnt_q != CNT_MAX)  flush_cnt_d  = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_q         <= '0;
      ex_rt_q      <= '0;
      ex_valid_q   <= 1'b0;
      mem_q        <= '0;
      mem_valid_q  <= 1'b0;
      wb_q         <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ex_q         <= ex_d;
      ex_rt_q      <= ex_rt_d;
      ex_valid_q   <= ex_valid_d;
      mem_q        <= mem_d;
      mem_valid_q  <= mem_valid_d;
      wb_q         <= wb_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ex_alusrc_o    = ex_q.alusrc;
  assign ex_regdst_o    = ex_q.regdst;
  assign ex_aluop_o     = ex_q.aluop;
  assign mem_branch_o   = mem_q.branch;
  assign mem_memread_o  = mem_q.memread;
  assign mem_memwrite_o = mem_q.memwrite;
  assign wb_regwrite_o  = wb_q.regwrite;
  assign wb_memtoreg_o  = wb_q.memtoreg;
  assign bubble_cnt_o   = bubble_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;

endmodule
